// File: rtl/seq_div.sv
// seq_div: iterative radix-2 restoring divider for DIV/DIVU in EX.
// Ports: clk, resetn (async low), signed_div_i, opdata1_i (dividend),
//   opdata2_i (divisor), start_i, annul_i -> result_o {rem,quo}, ready_o.
// Option: define DIV_EARLY_OUT_EN to finish early when |dividend| < |divisor|.
module seq_div (
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [64:0] r_work;
  logic [31:0] r_dvsr;
  logic        r_signed;
  logic        r_sign_a;
  logic        r_sign_b;
  logic [63:0] r_result;
  logic        r_ready;

  logic        w_accept;
  logic        w_abort;
  logic        w_last;
  logic        w_early;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [64:0] w_shift;
  logic [33:0] w_trial;
  logic [64:0] w_step;
  logic [31:0] w_raw_q;
  logic [31:0] w_raw_r;
  logic [31:0] w_fix_q;
  logic [31:0] w_fix_r;

  assign w_accept = start_i & ~annul_i;
  assign w_abort  = annul_i | ~start_i;
  assign w_last   = (r_cnt == 6'd31);

  assign w_sign_a = signed_div_i & opdata1_i[31];
  assign w_sign_b = signed_div_i & opdata2_i[31];
  // 0x80000000 negates to itself and is then used as an unsigned magnitude
  assign w_mag_a  = w_sign_a ? -opdata1_i : opdata1_i;
  assign w_mag_b  = w_sign_b ? -opdata2_i : opdata2_i;

  // one restoring step; 34-bit trial so the borrow is unambiguous
  assign w_shift = r_work << 1;
  assign w_trial = {1'b0, w_shift[64:32]} - {2'b00, r_dvsr};
  assign w_step  = w_trial[33] ? w_shift
                 : {w_trial[32:0], w_shift[31:0] | 32'd1};

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (r_cnt == 6'd0) && (r_work[31:0] < r_dvsr);
`else
  assign w_early = 1'b0;
`endif

  always_comb begin
    w_raw_q = w_step[31:0];
    w_raw_r = w_step[63:32];
    if (r_state == S_BY_ZERO) begin
      w_raw_q = 32'd0;
      w_raw_r = 32'd0;
    end else if (w_early) begin
      w_raw_q = 32'd0;
      w_raw_r = r_work[31:0];
    end
  end

  assign w_fix_q = (r_signed & (r_sign_a ^ r_sign_b)) ? -w_raw_q : w_raw_q;
  assign w_fix_r = (r_signed & r_sign_a) ? -w_raw_r : w_raw_r;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FREE: begin
        if (w_accept)
          w_state_nxt = (opdata2_i == 32'd0) ? S_BY_ZERO : S_ON;
      end
      S_BY_ZERO: w_state_nxt = S_END;
      S_ON: begin
        if (w_abort)
          w_state_nxt = S_FREE;
        else if (w_early || w_last)
          w_state_nxt = S_END;
      end
      S_END: begin
        if (!start_i)
          w_state_nxt = S_FREE;
      end
      default: w_state_nxt = S_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_FREE;
      r_cnt    <= 6'd0;
      r_work   <= 65'd0;
      r_dvsr   <= 32'd0;
      r_signed <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_result <= 64'd0;
      r_ready  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FREE) begin
        if (w_accept) begin
          r_signed <= signed_div_i;
          r_sign_a <= w_sign_a;
          r_sign_b <= w_sign_b;
          r_dvsr   <= w_mag_b;
          r_work   <= {33'd0, w_mag_a};
          r_cnt    <= 6'd0;
        end
      end else if (r_state == S_ON) begin
        if (w_abort) begin
          r_work <= 65'd0;
          r_cnt  <= 6'd0;
        end else begin
          r_work <= w_step;
          r_cnt  <= r_cnt + 6'd1;
        end
      end
      r_ready <= (w_state_nxt == S_END);
      if (w_state_nxt != S_END)
        r_result <= 64'd0;
      else if (r_state != S_END)
        r_result <= {w_fix_r, w_fix_q};
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed bench for seq_div with a result scoreboard.
// Expected {rem,quo} values are queued at issue and popped at ready.
module tb_seq_div;

  logic        clk;
  logic        resetn;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_pass;
  int n_total;
  logic [63:0] sb[$];

  seq_div dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int exp_lat(input logic s, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    begin
      logic [31:0] ma;
      logic [31:0] mb;
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      if (ma < mb) return 2;
    end
`endif
    return 33;
  endfunction

  // called at posedge+1; that cycle is cycle 0 of the request
  task automatic do_div(input string tag, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int cyc;
    int lat;
    logic [63:0] want;
    lat = exp_lat(s, a, b);
    sb.push_back(exp);
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    annul_i = 1'b0;
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        signed_div_i = ~s;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      if (cyc == 5 && !ready_o)
        chk({tag, "_busy_res"}, result_o, 64'd0);
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    want = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    chk({tag, "_res"}, result_o, want);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, {ready_o, result_o}, 65'd0);
  endtask

  initial begin
    logic        saw;
    logic [31:0] ra;
    logic [31:0] rb;
    n_pass = 0;
    n_total = 0;
    resetn = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {ready_o, result_o}, 65'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    do_div("div_5_0", 1'b1, 32'd5, 32'd0, 64'd0);
    do_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
           64'h00000000_80000000);
    do_div("divu_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC);
    do_div("divu_3_10", 1'b0, 32'd3, 32'd10, 64'h00000003_00000000);
    do_div("div_m3_10", 1'b1, 32'hFFFFFFFD, 32'd10, 64'hFFFFFFFD_00000000);
    do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
    do_div("divu_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i == 3) ? (ra + 32'd1) : $urandom_range(1, 100000);
      if (rb == 32'd0) rb = 32'd1;
      do_div("divu_rand", 1'b0, ra, rb, {ra % rb, ra / rb});
    end

    // abort at cycle 10, then a fresh request in the next cycle
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      saw |= ready_o;
    end
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    saw |= ready_o;
    annul_i = 1'b0;
    chk("annul_no_ready", 64'(saw), 64'd0);
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'd3);

    // reset in the middle of an operation
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_reset", {ready_o, result_o}, 65'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    start_i = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      saw |= ready_o;
    end
    chk("post_reset_idle", 64'(saw), 64'd0);
    do_div("after_reset", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
